kan_mac_pe: RTL and testbench

Parametrised multiply-accumulate processing element for the KAN accelerator datapath. It is the successor to the single-lane pipelined multiply PE. It processes LANES independent signed fixed-point lanes with a configurable multiply pipeline depth. Two modes are supported: per-beat product pass-through, and accumulation over a sequence closed by ilast. Rounding and saturation are applied to the output. It sits between the coefficient/activation fetch stage and the layer output buffer.

---
 rtl/kan_pe_pkg.sv | 44 ++++
 rtl/kan_mul_pipe.sv | 52 +++++
 rtl/kan_mac_pe.sv | 132 +++++++++++++
 tb/tb_kan_mac_pe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kan_pe_pkg.sv
// KAN MAC processing element: shared constants and arithmetic helpers.
// Fixed-point rounding and saturation used by the multiply pipe and accumulator.
package kan_pe_pkg;

  localparam int DEF_WORDSIZE = 16;
  localparam int DEF_FRAC     = 8;
  localparam int DEF_LANES    = 2;
  localparam int DEF_PIPE     = 3;
  localparam int DEF_ACCW     = 32;
  localparam int PRODW        = 2 * DEF_WORDSIZE;

  localparam logic signed [DEF_WORDSIZE-1:0] WORD_MAX =
    {1'b0, {(DEF_WORDSIZE-1){1'b1}}};
  localparam logic signed [DEF_WORDSIZE-1:0] WORD_MIN =
    {1'b1, {(DEF_WORDSIZE-1){1'b0}}};
  localparam logic signed [DEF_ACCW-1:0] ACC_MAX =
    {1'b0, {(DEF_ACCW-1){1'b1}}};
  localparam logic signed [DEF_ACCW-1:0] ACC_MIN =
    {1'b1, {(DEF_ACCW-1){1'b0}}};

  function automatic logic signed [63:0] sat_to_word(
    input logic signed [63:0] value,
    input int                 width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic logic signed [63:0] round_shift(
    input logic signed [63:0] product,
    input int                 frac
  );
    logic signed [63:0] v;
    v = product;
    if (frac > 0) v = v + (64'sd1 <<< (frac - 1));
    return v >>> frac;
  endfunction

endpackage

// File: rtl/kan_mul_pipe.sv
// Single-lane signed multiply with round-half-up rescale.
// Rescaled product is clipped to the accumulator width, then delayed PIPE stages.
module kan_mul_pipe
  import kan_pe_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter int FRAC     = DEF_FRAC,
  parameter int ACCW     = DEF_ACCW,
  parameter int PIPE     = DEF_PIPE
) (
  input  logic                       iclk,
  input  logic                       irstn,
  input  logic signed [WORDSIZE-1:0] xdata,
  input  logic signed [WORDSIZE-1:0] wdata,
  output logic signed [ACCW-1:0]     prod,
  output logic                       rsat
);

  localparam int PW = 2 * WORDSIZE;

  logic signed [PW-1:0] mul;
  logic signed [63:0]   rs;
  logic                 rs_sat;
  logic signed [ACCW-1:0] d [PIPE];
  logic [PIPE-1:0]        s;

  // Full-precision product, rescale, and detect clipping to ACCW
  always_comb begin
    mul    = PW'(xdata) * PW'(wdata);
    rs     = round_shift(64'(mul), FRAC);
    rs_sat = (rs != sat_to_word(rs, ACCW));
  end

  // Delay line carrying the rescaled product and its clip flag
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      for (int i = 0; i < PIPE; i++) d[i] <= '0;
      s <= '0;
    end else begin
      d[0] <= ACCW'(sat_to_word(rs, ACCW));
      s[0] <= rs_sat;
      for (int i = 1; i < PIPE; i++) begin
        d[i] <= d[i-1];
        s[i] <= s[i-1];
      end
    end
  end

  assign prod = d[PIPE-1];
  assign rsat = s[PIPE-1];

endmodule

// File: rtl/kan_mac_pe.sv
// Multi-lane multiply-accumulate PE with pass-through and sequence modes.
// Shared control pipeline; per-lane accumulator, sticky saturation and output clip.
module kan_mac_pe
  import kan_pe_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter int FRAC     = DEF_FRAC,
  parameter int LANES    = DEF_LANES,
  parameter int PIPE     = DEF_PIPE,
  parameter int ACCW     = DEF_ACCW
) (
  input  logic                      iclk,
  input  logic                      irstn,
  input  logic                      ivalid,
  input  logic                      ilast,
  input  logic                      imode,
  input  logic                      iclr,
  input  logic [LANES*WORDSIZE-1:0] xdata,
  input  logic [LANES*WORDSIZE-1:0] wdata,
  output logic [LANES*WORDSIZE-1:0] odata,
  output logic                      ovalid,
  output logic [LANES-1:0]          osat
);

  logic [PIPE-1:0] vp;
  logic [PIPE-1:0] lp;
  logic [PIPE-1:0] mp;
  logic            pv;
  logic            pl;
  logic            pm;

  // Control bits travel alongside the lane products; iclr kills in-flight beats
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      vp <= '0;
      lp <= '0;
      mp <= '0;
    end else begin
      lp[0] <= ilast;
      mp[0] <= imode;
      for (int i = 1; i < PIPE; i++) begin
        lp[i] <= lp[i-1];
        mp[i] <= mp[i-1];
      end
      if (iclr) begin
        vp <= '0;
      end else begin
        vp[0] <= ivalid;
        for (int i = 1; i < PIPE; i++) vp[i] <= vp[i-1];
      end
    end
  end

  assign pv = vp[PIPE-1];
  assign pl = lp[PIPE-1];
  assign pm = mp[PIPE-1];

  // Result strobe: every pass beat, or the closing beat of a sequence
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) ovalid <= 1'b0;
    else        ovalid <= !iclr && pv && (!pm || pl);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [ACCW-1:0]     prod;
    logic                       rsat;
    logic signed [ACCW-1:0]     acc;
    logic                       stk;
    logic signed [63:0]         sum;
    logic signed [ACCW-1:0]     accn;
    logic                       asat;
    logic signed [ACCW-1:0]     src;
    logic signed [WORDSIZE-1:0] word;
    logic                       csat;
    logic [WORDSIZE-1:0]        od;
    logic                       os;

    kan_mul_pipe #(
      .WORDSIZE(WORDSIZE),
      .FRAC    (FRAC),
      .ACCW    (ACCW),
      .PIPE    (PIPE)
    ) u_mul (
      .iclk (iclk),
      .irstn(irstn),
      .xdata(xdata[k*WORDSIZE +: WORDSIZE]),
      .wdata(wdata[k*WORDSIZE +: WORDSIZE]),
      .prod (prod),
      .rsat (rsat)
    );

    // Saturating accumulate and final clip to the lane word
    always_comb begin
      sum  = 64'(prod) + 64'(acc);
      accn = ACCW'(sat_to_word(sum, ACCW));
      asat = (sum != 64'(accn));
      src  = pm ? accn : prod;
      word = WORDSIZE'(sat_to_word(64'(src), WORDSIZE));
      csat = (64'(src) != 64'(word));
    end

    // Accumulator, sticky flag and held output for this lane
    always_ff @(posedge iclk or negedge irstn) begin
      if (!irstn) begin
        acc <= '0;
        stk <= 1'b0;
        od  <= '0;
        os  <= 1'b0;
      end else if (iclr) begin
        acc <= '0;
        stk <= 1'b0;
      end else if (pv) begin
        if (!pm) begin
          od <= word;
          os <= rsat | csat;
        end else if (pl) begin
          od  <= word;
          os  <= stk | rsat | asat | csat;
          acc <= '0;
          stk <= 1'b0;
        end else begin
          acc <= accn;
          stk <= stk | rsat | asat;
        end
      end
    end

    assign odata[k*WORDSIZE +: WORDSIZE] = od;
    assign osat[k] = os;
  end

endmodule

// File: tb/tb_kan_mac_pe.sv
// Directed self-checking bench for kan_mac_pe (16-bit Q8.8, 2 lanes, PIPE=3).
// Expected values are hand-computed fixed-point results.
module tb_kan_mac_pe;

  logic        iclk = 1'b0;
  logic        irstn = 1'b0;
  logic        ivalid = 1'b0;
  logic        ilast = 1'b0;
  logic        imode = 1'b0;
  logic        iclr = 1'b0;
  logic [31:0] xdata = '0;
  logic [31:0] wdata = '0;
  logic [31:0] odata;
  logic        ovalid;
  logic [1:0]  osat;

  int tests = 0;
  int fails = 0;

  kan_mac_pe #(
    .WORDSIZE(16),
    .FRAC    (8),
    .LANES   (2),
    .PIPE    (3),
    .ACCW    (32)
  ) dut (
    .iclk  (iclk),
    .irstn (irstn),
    .ivalid(ivalid),
    .ilast (ilast),
    .imode (imode),
    .iclr  (iclr),
    .xdata (xdata),
    .wdata (wdata),
    .odata (odata),
    .ovalid(ovalid),
    .osat  (osat)
  );

  always #5 iclk = ~iclk;

  task automatic tick;
    @(posedge iclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic l,
                       input logic [15:0] x0, input logic [15:0] w0,
                       input logic [15:0] x1, input logic [15:0] w1);
    ivalid = v;
    imode  = m;
    ilast  = l;
    xdata  = {x1, x0};
    wdata  = {w1, w0};
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_reset;
    irstn = 1'b0;
    #12;
    tests++;
    if (ovalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovalid got %b want 0", ovalid);
    end
    tests++;
    if (odata !== 32'h0) begin
      fails++;
      $display("FAIL reset_odata got %h want 00000000", odata);
    end
    tests++;
    if (osat !== 2'b00) begin
      fails++;
      $display("FAIL reset_osat got %b want 00", osat);
    end
    @(negedge iclk);
    irstn = 1'b1;
    tick;
    tick;
    tests++;
    if (ovalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_ovalid got %b want 0", ovalid);
    end
  endtask

  task automatic test_mode0_latency;
    int n;
    drive(1'b1, 1'b0, 1'b0, 16'h0180, 16'h0200, 16'hFF00, 16'h0100);
    tick;
    idle;
    n = 1;
    while (ovalid !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL m0_latency got %0d want 4", n);
    end
    tests++;
    if (odata !== 32'hFF00_0300) begin
      fails++;
      $display("FAIL m0_odata got %h want ff000300", odata);
    end
    tests++;
    if (osat !== 2'b00) begin
      fails++;
      $display("FAIL m0_osat got %b want 00", osat);
    end
    tick;
    tests++;
    if (ovalid !== 1'b0 || odata !== 32'hFF00_0300) begin
      fails++;
      $display("FAIL m0_hold got v=%b d=%h want v=0 d=ff000300",
               ovalid, odata);
    end
  endtask

  task automatic test_accumulate;
    logic ev;
    for (int c = 0; c < 12; c++) begin
      if (c < 4)
        drive(1'b1, 1'b1, c == 3, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      else if (c < 6)
        drive(1'b1, 1'b1, c == 5, 16'h0080, 16'h0100, 16'h0080, 16'h0100);
      else
        idle;
      tick;
      ev = (c == 6) || (c == 8);
      tests++;
      if (ovalid !== ev) begin
        fails++;
        $display("FAIL acc_ovalid c=%0d got %b want %b", c, ovalid, ev);
      end
      if (c == 6) begin
        tests++;
        if (odata !== 32'h0400_0400 || osat !== 2'b00) begin
          fails++;
          $display("FAIL acc_seq1 got %h/%b want 04000400/00", odata, osat);
        end
      end
      if (c == 8) begin
        tests++;
        if (odata !== 32'h0100_0100 || osat !== 2'b00) begin
          fails++;
          $display("FAIL acc_seq2 got %h/%b want 01000100/00", odata, osat);
        end
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] ed [3];
    logic [1:0]  es [3];
    ed[0] = 32'h0200_7FFF; es[0] = 2'b01;
    ed[1] = 32'h0100_8000; es[1] = 2'b01;
    ed[2] = 32'h0200_0200; es[2] = 2'b00;
    for (int c = 0; c < 9; c++) begin
      if (c < 2)
        drive(1'b1, 1'b1, c == 1, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100);
      else if (c == 2)
        drive(1'b1, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 16'h0100, 16'h0100);
      else if (c == 3)
        drive(1'b1, 1'b1, 1'b1, 16'h0100, 16'h0200, 16'h0100, 16'h0200);
      else
        idle;
      tick;
      if (c >= 4 && c <= 6) begin
        tests++;
        if (ovalid !== 1'b1 || odata !== ed[c-4] || osat !== es[c-4]) begin
          fails++;
          $display("FAIL sat_out c=%0d got v=%b d=%h s=%b want v=1 d=%h s=%b",
                   c, ovalid, odata, osat, ed[c-4], es[c-4]);
        end
      end else begin
        tests++;
        if (ovalid !== 1'b0) begin
          fails++;
          $display("FAIL sat_ovalid c=%0d got %b want 0", c, ovalid);
        end
      end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] ed [3];
    ed[0] = 32'hFFFF_0001;
    ed[1] = 32'h0000_0000;
    ed[2] = 32'h0000_0000;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)
        drive(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0080, 16'hFFFF, 16'h0081);
      else if (c == 1)
        drive(1'b1, 1'b0, 1'b0, 16'h0001, 16'h007F, 16'h0001, 16'h007F);
      else if (c == 2)
        drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0080, 16'hFFFF, 16'h0080);
      else
        idle;
      tick;
      if (c >= 3 && c <= 5) begin
        tests++;
        if (ovalid !== 1'b1 || odata !== ed[c-3] || osat !== 2'b00) begin
          fails++;
          $display("FAIL round c=%0d got v=%b d=%h s=%b want v=1 d=%h s=00",
                   c, ovalid, odata, osat, ed[c-3]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    drive(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0100, 16'h0300, 16'h0100);
    tick;
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    tick;
    tick;
    idle;
    tick;
    tests++;
    if (ovalid !== 1'b1 || odata !== 32'h0300_0300) begin
      fails++;
      $display("FAIL rstmid_pre got v=%b d=%h want v=1 d=03000300",
               ovalid, odata);
    end
    #2;
    irstn = 1'b0;
    #1;
    tests++;
    if (ovalid !== 1'b0 || odata !== 32'h0 || osat !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_async got v=%b d=%h s=%b want v=0 d=0 s=00",
               ovalid, odata, osat);
    end
    #1;
    irstn = 1'b1;
    tick;
    drive(1'b1, 1'b1, 1'b1, 16'h0200, 16'h0100, 16'h0200, 16'h0100);
    tick;
    idle;
    n = 1;
    while (ovalid !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    tests++;
    if (n !== 4 || odata !== 32'h0200_0200) begin
      fails++;
      $display("FAIL rstmid_fresh got n=%0d d=%h want n=4 d=02000200",
               n, odata);
    end
  endtask

  task automatic test_clear;
    int n;
    for (int c = 0; c < 13; c++) begin
      iclr = 1'b0;
      if (c == 0)
        drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      else if (c == 5)
        drive(1'b1, 1'b0, 1'b0, 16'h0500, 16'h0100, 16'h0500, 16'h0100);
      else if (c == 6) begin
        drive(1'b1, 1'b0, 1'b0, 16'h0700, 16'h0100, 16'h0700, 16'h0100);
        iclr = 1'b1;
      end else
        idle;
      tick;
      tests++;
      if (ovalid !== 1'b0 || odata !== 32'h0200_0200) begin
        fails++;
        $display("FAIL clr_quiet c=%0d got v=%b d=%h want v=0 d=02000200",
                 c, ovalid, odata);
      end
    end
    iclr = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 16'h0300, 16'h0100, 16'h0300, 16'h0100);
    tick;
    idle;
    n = 1;
    while (ovalid !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    tests++;
    if (n !== 4 || odata !== 32'h0300_0300 || osat !== 2'b00) begin
      fails++;
      $display("FAIL clr_fresh got n=%0d d=%h s=%b want n=4 d=03000300 s=00",
               n, odata, osat);
    end
  endtask

  initial begin
    test_reset;
    test_mode0_latency;
    test_accumulate;
    test_saturation;
    test_rounding;
    test_reset_mid;
    test_clear;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
